// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared op/size codes and return-tag type for mem_port_arbiter
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_DISABLE   = 2'b00,
        MEM_READ_SEXT = 2'b01,
        MEM_READ_ZEXT = 2'b10,
        MEM_WRITE     = 2'b11
    } mem_op_e;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALFWORD  = 2'b01,
        WORD      = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    // Everything the response cycle needs, captured in the grant cycle.
    typedef struct packed {
        owner_e    owner;
        logic      isRead;
        logic      err;
        logic      sext;
        mem_size_e size;
        logic [1:0] addrLo;
    } ret_tag_t;

    function automatic logic isBadAccess(input mem_size_e size, input logic [1:0] addrLo);
        logic bad;
        case (size)
            BYTE:     bad = 1'b0;
            HALFWORD: bad = addrLo[0];
            WORD:     bad = |addrLo;
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - core-side fetch (I) and load/store (D) port bundle
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    logic        d_req;
    logic [1:0]  d_op;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    modport master (
        output i_req, i_addr, d_req, d_op, d_size, d_addr, d_wdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err
    );

    modport slave (
        input  i_req, i_addr, d_req, d_op, d_size, d_addr, d_wdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err
    );
endinterface

// File: rtl/mem_port_arbiter_lane_align.sv
// rtl/mem_port_arbiter_lane_align.sv - byte-lane steering; LOAD=0 builds store lanes, LOAD=1 extracts and extends
module mem_lane_align
    import mem_pkg::*;
#(
    parameter bit LOAD = 1'b0
) (
    input  mem_size_e   size,
    input  logic [1:0]  addrLo,
    input  logic        sext,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic [3:0]  byteEn
);

    if (LOAD) begin : gLoad
        logic [7:0]  pickByte;
        logic [15:0] pickHalf;

        always_comb begin
            pickByte = dataIn[{addrLo, 3'b000} +: 8];
            pickHalf = addrLo[1] ? dataIn[31:16] : dataIn[15:0];
            case (size)
                BYTE:     dataOut = {{24{sext & pickByte[7]}}, pickByte};
                HALFWORD: dataOut = {{16{sext & pickHalf[15]}}, pickHalf};
                default:  dataOut = dataIn;
            endcase
        end

        assign byteEn = 4'b0000;
    end else begin : gStore
        wire unusedSext = sext;

        // Replicate the right-justified data so whichever lane is enabled sees it.
        always_comb begin
            byteEn  = 4'b0000;
            dataOut = 32'h0;
            case (size)
                BYTE: begin
                    byteEn  = 4'b0001 << addrLo;
                    dataOut = {4{dataIn[7:0]}};
                end
                HALFWORD: begin
                    byteEn  = addrLo[1] ? 4'b1100 : 4'b0011;
                    dataOut = {2{dataIn[15:0]}};
                end
                WORD: begin
                    byteEn  = 4'b1111;
                    dataOut = dataIn;
                end
                default: begin
                    byteEn  = 4'b0000;
                    dataOut = 32'h0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - I/D arbiter for one sync RAM; MEM_ARB_STARVE_GUARD_EN enables the I starvation guard
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int RAM_AW     = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    mem_op_e   dOp;
    mem_size_e dSize;
    logic      iEff, dEff, dBad, dGood, dWrite, forceI, iGnt, dGnt;
    ret_tag_t  tag;
    logic [31:0] storeData, loadData;
    logic [3:0]  storeBe, unusedLoadBe;

    wire unusedAddrBits = ^{bus.i_addr[1:0], bus.i_addr[31:RAM_AW+2], bus.d_addr[31:RAM_AW+2]};

    assign dOp    = mem_op_e'(bus.d_op);
    assign dSize  = mem_size_e'(bus.d_size);
    assign iEff   = bus.i_req;
    assign dEff   = bus.d_req && (dOp != MEM_DISABLE);
    assign dBad   = isBadAccess(dSize, bus.d_addr[1:0]);
    assign dWrite = (dOp == MEM_WRITE);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starveCnt;

    assign forceI = iEff && (starveCnt == CW'(STARVE_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starveCnt <= '0;
        end else if (!iEff || iGnt) begin
            starveCnt <= '0;
        end else if (starveCnt != CW'(STARVE_MAX)) begin
            starveCnt <= starveCnt + 1'b1;
        end
    end
`else
    localparam int unusedStarveMax = STARVE_MAX;
    assign forceI = 1'b0;
`endif

    // A granted bad D access still owns the cycle, so I cannot slip in behind it.
    assign dGnt  = dEff && !forceI;
    assign iGnt  = iEff && !dGnt;
    assign dGood = dGnt && !dBad;

    assign bus.i_gnt = iGnt;
    assign bus.d_gnt = dGnt;

    mem_lane_align #(.LOAD(1'b0)) uStoreAlign (
        .size    (dSize),
        .addrLo  (bus.d_addr[1:0]),
        .sext    (1'b0),
        .dataIn  (bus.d_wdata),
        .dataOut (storeData),
        .byteEn  (storeBe)
    );

    always_comb begin
        ram_en    = iGnt || dGood;
        ram_we    = 4'b0000;
        ram_wdata = 32'h0;
        ram_addr  = '0;
        if (iGnt) begin
            ram_addr = bus.i_addr[RAM_AW+1:2];
        end else if (dGood) begin
            ram_addr = bus.d_addr[RAM_AW+1:2];
            if (dWrite) begin
                ram_we    = storeBe;
                ram_wdata = storeData;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag <= '0;
        end else begin
            tag.owner  <= dGnt ? OWNER_D : OWNER_I;
            tag.isRead <= iGnt || (dGood && !dWrite);
            tag.err    <= dGnt && dBad;
            tag.sext   <= (dOp == MEM_READ_SEXT);
            tag.size   <= dSize;
            tag.addrLo <= bus.d_addr[1:0];
        end
    end

    mem_lane_align #(.LOAD(1'b1)) uLoadAlign (
        .size    (tag.size),
        .addrLo  (tag.addrLo),
        .sext    (tag.sext),
        .dataIn  (ram_rdata),
        .dataOut (loadData),
        .byteEn  (unusedLoadBe)
    );

    assign bus.i_rvalid = tag.isRead && (tag.owner == OWNER_I);
    assign bus.d_rvalid = tag.isRead && (tag.owner == OWNER_D);
    assign bus.d_err    = tag.err;
    assign bus.i_rdata  = bus.i_rvalid ? ram_rdata : 32'h0;
    assign bus.d_rdata  = bus.d_rvalid ? loadData : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int RAM_AW     = 12;
    localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = 32'h0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.RAM_AW(RAM_AW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Environment RAM: synchronous, one-cycle read latency, byte enables.
    logic [31:0] ram [0:4095];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'b0000) ram_rdata <= ram[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state: memory image, starvation count, pending responses.
    logic [31:0] refMem [0:4095];
    int          starve = 0;
    logic        pendI = 0, pendD = 0, pendErr = 0;
    logic [31:0] pendIData = 0, pendDData = 0;
    logic [31:0] dSeen [$];
    logic        iGntSeen [$];
    logic        obsIGnt, obsDGnt, obsRamEn, obsDErr, obsDRvalid;
    logic [3:0]  obsRamWe;

    function automatic logic [31:0] refLoad(input logic [31:0] addr, input logic [1:0] sz, input logic sx);
        int nB = 1 << sz;
        logic [31:0] mask = (nB == 4) ? 32'hffffffff : ((32'd1 << (8 * nB)) - 1);
        logic [31:0] v = (refMem[addr[13:2]] >> (8 * addr[1:0])) & mask;
        if (sx && nB < 4 && v[8*nB-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic cyc(input logic ir, input logic [31:0] ia, input logic dr, input logic [1:0] op,
                       input logic [1:0] sz, input logic [31:0] da, input logic [31:0] wd);
        logic fI, eD, eI, bad, good, wr;
        int nB;
        logic [3:0] eWe;
        bus.i_req = ir; bus.i_addr = ia; bus.d_req = dr; bus.d_op = op;
        bus.d_size = sz; bus.d_addr = da; bus.d_wdata = wd;
        #4;
        fI   = GUARD && ir && (starve == STARVE_MAX);
        eD   = dr && (op != 2'b00) && !fI;
        eI   = ir && !eD;
        nB   = 1 << sz;
        bad  = (sz == 2'b11) || ((int'(da[1:0]) % nB) != 0);
        good = eD && !bad;
        wr   = (op == 2'b11);
        eWe  = (good && wr) ? 4'(((1 << nB) - 1) << da[1:0]) : 4'b0000;
        checkEq("i_gnt", bus.i_gnt, eI);
        checkEq("d_gnt", bus.d_gnt, eD);
        checkEq("ram_en", ram_en, eI || good);
        checkEq("ram_we", ram_we, eWe);
        if (eI || good) checkEq("ram_addr", ram_addr, eI ? ia[13:2] : da[13:2]);
        checkEq("i_rvalid", bus.i_rvalid, pendI);
        if (pendI) checkEq("i_rdata", bus.i_rdata, pendIData);
        checkEq("d_rvalid", bus.d_rvalid, pendD);
        if (pendD) checkEq("d_rdata", bus.d_rdata, pendDData);
        checkEq("d_err", bus.d_err, pendErr);
        obsIGnt = bus.i_gnt; obsDGnt = bus.d_gnt; obsRamEn = ram_en; obsRamWe = ram_we;
        obsDErr = bus.d_err; obsDRvalid = bus.d_rvalid;
        if (bus.d_rvalid) dSeen.push_back(bus.d_rdata);
        iGntSeen.push_back(bus.i_gnt);
        pendIData = refMem[ia[13:2]];
        if (good && !wr) pendDData = refLoad(da, sz, op == 2'b01);
        if (good && wr)
            for (int k = 0; k < nB; k++)
                refMem[da[13:2]][8*(int'(da[1:0]) + k) +: 8] = wd[8*k +: 8];
        if (!ir || eI) starve = 0;
        else if (starve < STARVE_MAX) starve++;
        pendI = eI; pendD = good && !wr; pendErr = eD && bad;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    endtask

    initial begin
        for (int w = 0; w < 4096; w++) begin ram[w] = 32'h0; refMem[w] = 32'h0; end
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_op = 0;
        bus.d_size = 0; bus.d_addr = 0; bus.d_wdata = 0;
        #2;
        checkEq("rst_gnts", {bus.i_gnt, bus.d_gnt}, 2'b00);
        checkEq("rst_rvalids", {bus.i_rvalid, bus.d_rvalid, bus.d_err}, 3'b000);
        checkEq("rst_ram", {ram_en, ram_we}, 5'b0);
        checkEq("rst_i_rdata", bus.i_rdata, 32'h0);
        checkEq("rst_d_rdata", bus.d_rdata, 32'h0);
        @(posedge clk); #1; rst = 1'b0;

        // Word writes then back-to-back zext word reads.
        cyc(0, 0, 1, 2'b11, 2'b10, 32'h8000_0000, 32'hdeadbeef);
        cyc(0, 0, 1, 2'b11, 2'b10, 32'h8000_0004, 32'hcafebabe);
        cyc(0, 0, 1, 2'b11, 2'b10, 32'h8000_0008, 32'h12345678);
        dSeen.delete();
        cyc(0, 0, 1, 2'b10, 2'b10, 32'h8000_0000, 0);
        cyc(0, 0, 1, 2'b10, 2'b10, 32'h8000_0004, 0);
        cyc(0, 0, 1, 2'b10, 2'b10, 32'h8000_0008, 0);
        idle();
        checkEq("rd3_count", dSeen.size(), 3);
        if (dSeen.size() == 3) begin
            checkEq("rd_w0", dSeen[0], 32'hdeadbeef);
            checkEq("rd_w1", dSeen[1], 32'hcafebabe);
            checkEq("rd_w2", dSeen[2], 32'h12345678);
        end

        // Byte sign extension and halfword zero extension.
        cyc(0, 0, 1, 2'b11, 2'b10, 32'h8000_0060, 32'h0eadcafe);
        dSeen.delete();
        for (int k = 0; k < 4; k++) cyc(0, 0, 1, 2'b01, 2'b00, 32'h8000_0060 + k, 0);
        cyc(0, 0, 1, 2'b10, 2'b01, 32'h8000_0062, 0);
        idle();
        checkEq("ext_count", dSeen.size(), 5);
        if (dSeen.size() == 5) begin
            checkEq("sext_b0", dSeen[0], 32'hfffffffe);
            checkEq("sext_b1", dSeen[1], 32'hffffffca);
            checkEq("sext_b2", dSeen[2], 32'hffffffad);
            checkEq("sext_b3", dSeen[3], 32'h0000000e);
            checkEq("zext_h1", dSeen[4], 32'h00000ead);
        end

        // Upper halfword store keeps the low half.
        cyc(0, 0, 1, 2'b11, 2'b10, 32'h8000_0020, 32'haaaa5555);
        cyc(0, 0, 1, 2'b11, 2'b01, 32'h8000_0022, 32'h00008765);
        checkEq("hw_we", obsRamWe, 4'b1100);
        dSeen.delete();
        cyc(0, 0, 1, 2'b10, 2'b10, 32'h8000_0020, 0);
        idle();
        checkEq("hw_count", dSeen.size(), 1);
        if (dSeen.size() == 1) checkEq("hw_word", dSeen[0], 32'h87655555);

        // Contention for 10 cycles.
        idle();
        iGntSeen.delete();
        for (int k = 0; k < 10; k++) cyc(1, 32'h8000_0100, 1, 2'b10, 2'b10, 32'h8000_0004, 0);
        for (int k = 0; k < 10; k++)
            checkEq($sformatf("starve_i%0d", k), iGntSeen[k], GUARD && (k % 5 == 4));
        idle();

        // Misaligned word read blocks the RAM for that cycle.
        cyc(1, 32'h8000_0008, 1, 2'b01, 2'b10, 32'h8000_0002, 0);
        checkEq("mis_d_gnt", obsDGnt, 1'b1);
        checkEq("mis_ram_en", obsRamEn, 1'b0);
        checkEq("mis_i_gnt", obsIGnt, 1'b0);
        cyc(1, 32'h8000_0008, 0, 2'b00, 2'b00, 0, 0);
        checkEq("mis_err", obsDErr, 1'b1);
        checkEq("mis_rvalid", obsDRvalid, 1'b0);
        checkEq("mis_i_next", obsIGnt, 1'b1);
        idle();

        // Reset right after a read grant drops the response.
        cyc(1, 32'h8000_0004, 0, 2'b00, 2'b00, 0, 0);
        bus.i_req = 0;
        rst = 1'b1;
        #4;
        checkEq("mrst_valids", {bus.i_rvalid, bus.d_rvalid, bus.d_err}, 3'b000);
        checkEq("mrst_rdata", bus.i_rdata | bus.d_rdata, 32'h0);
        checkEq("mrst_ram", {ram_en, ram_we, ram_addr}, 17'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        pendI = 0; pendD = 0; pendErr = 0; starve = 0;
        idle();
        idle();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 1), 32'h8000_0000 | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3),
                $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                32'h8000_0000 | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3), $urandom);
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM (1-cycle read latency, byte write enables) between two requesters: the instruction fetch port (I) and the load/store data port (D).
- Each cycle it grants at most one requester.
- Generates byte lanes for D stores, then aligns and sign- or zero-extends D load data.
- Returns read data with a valid strobe one cycle after grant. It sits between the core pipeline and the RAM wrapper.

Parameters:
- RAM_AW, 12, word-address width of the RAM; ram_addr = addr[RAM_AW+1:2], upper address bits ignored.
- STARVE_MAX, 4, consecutive cycles I may be denied while requesting before I is forced to win. Used only with MEM_ARB_STARVE_GUARD_EN.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  I requests a word read
- i_addr  in  32  I byte address, word aligned (bits [1:0] ignored)
- i_gnt  out  1  I request accepted this cycle
- i_rvalid  out  1  i_rdata valid; asserted the cycle after i_gnt
- i_rdata  out  32  fetched word
- d_req  in  1  D request
- d_op  in  2  00 disable, 01 read sext, 10 read zext, 11 write
- d_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- d_addr  in  32  D byte address
- d_wdata  in  32  store data, right-justified
- d_gnt  out  1  D request accepted this cycle
- d_rvalid  out  1  d_rdata valid, the cycle after a read d_gnt
- d_rdata  out  32  aligned and extended load data
- d_err  out  1  one-cycle pulse, the cycle after a granted misaligned or reserved-size D access
- ram_en  out  1  RAM access strobe
- ram_we  out  4  byte write enables; bit n controls bits [8n+7:8n]
- ram_addr  out  RAM_AW  word address
- ram_wdata  out  32  lane-replicated store data
- ram_rdata  in  32  RAM output, valid the cycle after ram_en with ram_we=0

Behaviour:
- Reset values: i_gnt, d_gnt, i_rvalid, d_rvalid, d_err, ram_en and ram_we are 0; i_rdata and d_rdata are 0. Starvation counter and return tag are cleared.
- A D request is effective when d_req=1 and d_op!=00. I is effective when i_req=1.
- Arbitration is combinational in the same cycle, with D priority. If both are effective, D wins, unless the starvation guard forces I (see Optional Feature).
- Grant outputs are combinational. The ram_* outputs are combinational from the winner. Fully pipelined: one grant per cycle, no bubbles.
- Return path registers the following in the grant cycle: owner (I/D), read flag, ext (sext/zext), size, addr[1:0].
- In cycle N+1 the block asserts the owner's rvalid and drives its rdata from ram_rdata, through the lane aligner.
- Writes are granted but produce no rvalid.
- D read alignment:
  - Byte: lane addr[1:0].
  - Halfword: lane addr[1].
  - Word: as is.
  - Extension per d_op.
- Store lanes:
  - Byte: ram_we = 0001 shifted by addr[1:0], wdata byte replicated ×4.
  - Halfword: ram_we = 0011 or 1100, halfword replicated ×2.
  - Word: ram_we = 1111.
- Misaligned accesses (halfword with addr[0]=1, word with addr[1:0]!=0) and size=11:
  - The request is granted with ram_en=0 that cycle, so no RAM access occurs.
  - d_err pulses in N+1.
  - d_rvalid stays 0.
  - I may not use the RAM in that cycle.
- Store then load to the same word in consecutive cycles: the load returns the new data.
- Requests held high after a grant are new requests, one per cycle. Inputs are sampled only in the grant cycle.
- Reset asserted mid-operation: an in-flight rvalid or d_err is dropped and never emitted after reset release.

Optional Feature:
- MEM_ARB_STARVE_GUARD_EN defined: a counter increments each cycle I is effective but not granted, and clears on i_gnt or when I is not requesting.
  - When counter == STARVE_MAX, I wins over D for that cycle.
  - Counter saturates, never wraps.
- Not defined: strict D priority; I waits indefinitely; no counter logic.

Decomposition:
- Package mem_pkg holds:
  - d_op codes MEM_DISABLE, MEM_READ_SEXT, MEM_READ_ZEXT, MEM_WRITE.
  - Sizes BYTE, HALFWORD, WORD.
  - The return-tag struct/typedef.
- Sub-module mem_lane_align, purely combinational, is instantiated twice:
  - Store direction: lanes and replication.
  - Load direction: extract and extend.

Test Plan:
- Write 0xdeadbeef, then 0xcafebabe, then 0x12345678 to 0x8000_0000, 0x8000_0004, 0x8000_0008 (word), then read each back with zext. Required: d_rvalid one cycle after each read d_gnt, data matching in order, back-to-back with no gaps.
- Write word 0x0eadcafe at 0x8000_0060, then sext byte reads at 0x60..0x63. Required: 0xfffffffe, 0xffffffca, 0xffffffad, 0x0000000e. The zext halfword read at 0x62 returns 0x00000ead.
- Write halfword 0x8765 at 0x8000_0022. Required: ram_we=1100. A word read of 0x8000_0020 returns 0x8765xxxx with the low half unchanged.
- i_req and d_req both held high for 10 cycles with the macro defined and STARVE_MAX=4. Required: i_gnt on every 5th cycle, d_gnt on all others. Without the macro, i_gnt stays 0 throughout.
- Word read at 0x8000_0002. Required: d_gnt=1, ram_en=0, d_err pulse the next cycle, no d_rvalid; a same-cycle i_req is granted in the following cycle.
- Assert rst the cycle after a read grant. Required: no rvalid emitted; all outputs 0 until a new grant.
